pipeline_run_controller: RTL
============================

# pipeline_run_controller

Sequences the five-stage MIPS pipeline by generating the global pipe-enable that every stage register, including the EX/MEM register, qualifies on. Accepts run/step/stop commands from the debug front end, free-runs or single-steps the pipeline, and detects the halt instruction. On halt it drains the in-flight instructions for a fixed number of cycles, then freezes. It also keeps an enabled-cycle counter for the debug front end to read back.

## Interface
- NB_CYCLES, 32, width of the enabled-cycle counter
- N_DRAIN, 4, enable cycles granted after halt is fetched (IF/ID to WB); legal range 1..15
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_cmd_valid  in  1  command present
- i_cmd  in  2  2'b00 NOP, 2'b01 RUN, 2'b10 STEP, 2'b11 STOP
- o_cmd_ready  out  1  command accepted at the edge where valid&ready
- i_halt_fetched  in  1  halt opcode present in IF/ID this cycle
- o_pipe_enabled  out  1  global pipeline enable
- o_state  out  3  current state encoding
- o_done  out  1  one-cycle pulse, step complete or halt reached
- o_halted  out  1  pipeline frozen after halt
- o_cycle_count  out  NB_CYCLES  count of cycles with o_pipe_enabled=1

## Operation
- States (o_state): IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4. Encodings 5..7 are unreachable; if entered, go to IDLE.
- Moore outputs:
  - o_pipe_enabled=1 in RUN, STEP, DRAIN.
  - o_cmd_ready=1 in IDLE, RUN, HALTED.
  - o_halted=1 in HALTED.
- IDLE: RUN→RUN; STEP→STEP; STOP/NOP accepted, no effect.
- RUN:
  - i_halt_fetched=1 → DRAIN, drain counter loaded with N_DRAIN.
  - Else an accepted STOP → IDLE.
  - RUN/STEP/NOP accepted and ignored.
  - Halt beats a simultaneous STOP.
- STEP: lasts exactly one cycle.
  - i_halt_fetched=1 → DRAIN (load N_DRAIN).
  - Else → IDLE with o_done pulse.
  - Commands not accepted in STEP (ready=0).
- DRAIN:
  - Drain counter decrements each cycle; commands not accepted.
  - In the cycle the counter equals 1 → HALTED, o_done pulse.
  - i_halt_fetched is ignored.
- HALTED: terminal until reset. Commands accepted and ignored; o_pipe_enabled=0.
- i_halt_fetched is sampled only in RUN and STEP.
- o_cycle_count: +1 every cycle o_pipe_enabled=1. Saturates at all-ones, no wrap. Never cleared except by reset.
- o_done: registered; high for the first cycle in the destination state (IDLE after STEP, HALTED after DRAIN).

## Timing
- Reset (i_rst_n=0, async):
  - state=IDLE
  - o_pipe_enabled=0, o_cmd_ready=1, o_done=0, o_halted=0
  - o_cycle_count=0, drain counter=0
- Reset release is used synchronously; the first transition can occur at the first rising edge with i_rst_n=1.
- Command accepted at edge k → new state and outputs visible in cycle k+1. Latency from RUN command to first enabled cycle is 1.
- Single step: exactly one cycle of o_pipe_enabled=1, followed by o_done=1 in the next cycle with enable=0.
- Halt fetched at edge k (RUN) → DRAIN for cycles k+1..k+N_DRAIN (enable high); HALTED plus o_done in cycle k+N_DRAIN+1.
- Total enable cycles including the halt-detect cycle = run cycles + N_DRAIN.
- Reset asserted mid-RUN/DRAIN: immediate return to reset values; no o_done.

## Test plan
- Reset: hold i_rst_n=0 with i_cmd_valid=1, RUN → state 0, enable 0, count 0, ready 1; release, idle with NOP for 5 cycles → count stays 0.
- Step: three STEP commands separated by 3 idle cycles → each gives exactly one enable cycle plus one o_done pulse; count=3; ready low during each STEP cycle.
- Run to halt: RUN, assert i_halt_fetched on the 10th enabled cycle, N_DRAIN=4 → enable high 14 cycles total; HALTED, o_done pulse, o_halted=1; count=14; later RUN ignored, count stays 14.
- Stop/halt collision: RUN; after 5 cycles drive STOP with i_halt_fetched in the same cycle → DRAIN (not IDLE); separately, STOP alone after 5 cycles → IDLE, count=5, no o_done.
- Halt during step: STEP with i_halt_fetched=1 → DRAIN, no step o_done; after 4 cycles HALTED with one o_done; count=5.
- Reset mid-drain and saturation: drop i_rst_n during DRAIN cycle 2 → all outputs at reset values in the same cycle. With NB_CYCLES=4, RUN for 20 cycles → count holds 15.

Source files
------------

// File: rtl/pipeline_run_controller.sv
// Global pipe-enable sequencer: run, single-step and halt-drain control
// for the five-stage pipeline, plus a saturating enabled-cycle counter.
module pipeline_run_controller #(
  parameter int NB_CYCLES = 32,
  parameter int N_DRAIN   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  output logic                 o_cmd_ready,
  input  logic                 i_halt_fetched,
  output logic                 o_pipe_enabled,
  output logic [2:0]           o_state,
  output logic                 o_done,
  output logic                 o_halted,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;
  localparam logic [3:0] DRAIN_LD = 4'(N_DRAIN);

  state_t         state;
  state_t         state_nx;
  logic [3:0]     drain_cnt;
  logic [3:0]     drain_nx;
  logic           done_nx;
  logic           accept;
  logic [NB_CYCLES-1:0] cnt;

  assign o_pipe_enabled = (state == S_RUN) ||
                          (state == S_STEP) ||
                          (state == S_DRAIN);
  assign o_cmd_ready    = (state == S_IDLE) ||
                          (state == S_RUN) ||
                          (state == S_HALTED);
  assign o_halted       = (state == S_HALTED);
  assign o_state        = state;
  assign o_cycle_count  = cnt;
  assign accept         = i_cmd_valid && o_cmd_ready;

  always_comb begin
    state_nx = state;
    drain_nx = drain_cnt;
    done_nx  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept && i_cmd == CMD_RUN)
          state_nx = S_RUN;
        else if (accept && i_cmd == CMD_STEP)
          state_nx = S_STEP;
      end
      S_RUN: begin
        // halt wins over a STOP in the same cycle
        if (i_halt_fetched) begin
          state_nx = S_DRAIN;
          drain_nx = DRAIN_LD;
        end else if (accept && i_cmd == CMD_STOP) begin
          state_nx = S_IDLE;
        end
      end
      S_STEP: begin
        if (i_halt_fetched) begin
          state_nx = S_DRAIN;
          drain_nx = DRAIN_LD;
        end else begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      S_DRAIN: begin
        drain_nx = drain_cnt - 4'd1;
        if (drain_cnt <= 4'd1) begin
          state_nx = S_HALTED;
          drain_nx = 4'd0;
          done_nx  = 1'b1;
        end
      end
      S_HALTED: state_nx = S_HALTED;
      default: begin
        state_nx = S_IDLE;
        drain_nx = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      drain_cnt <= 4'd0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_nx;
      o_done    <= done_nx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      cnt <= '0;
    else if (o_pipe_enabled && cnt != '1)
      cnt <= cnt + NB_CYCLES'(1);
  end

endmodule
